// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-back data cache:
//   - default geometry (lines, words per line) and the derived address widths
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int DCACHE_LINES      = 32;
    localparam int DCACHE_LINE_WORDS = 4;

    localparam int IDX_W  = $clog2(DCACHE_LINES);
    localparam int OFF_W  = $clog2(DCACHE_LINE_WORDS) + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = 32 * DCACHE_LINE_WORDS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_UPDATE    = 2'd3
    } dc_state_e;

endpackage

// File: rtl/dcache_sram.sv
// ---------------------------------------------------------------------------
// dcache_sram
// Tag / valid / dirty / data storage for the cache. All reads are
// combinational at idx_i; writes happen on the rising clock edge.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset (valid/dirty only)
//   idx_i               line index for both read and write
//   valid_o, dirty_o,
//   tag_o, line_o       contents of the indexed line
//   word_we_i           write one word (word_sel_i, word_i) and mark dirty
//   line_we_i           write full line (line_i, tag_i), set valid, dirty=dirty_i
// ---------------------------------------------------------------------------
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DCACHE_LINES,
    parameter int LINE_WORDS = DCACHE_LINE_WORDS,
    parameter int TAG_BITS   = TAG_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [$clog2(NUM_LINES)-1:0]     idx_i,
    output logic                             valid_o,
    output logic                             dirty_o,
    output logic [TAG_BITS-1:0]              tag_o,
    output logic [32*LINE_WORDS-1:0]         line_o,
    input  logic                             word_we_i,
    input  logic [$clog2(LINE_WORDS)-1:0]    word_sel_i,
    input  logic [31:0]                      word_i,
    input  logic                             line_we_i,
    input  logic [TAG_BITS-1:0]              tag_i,
    input  logic [32*LINE_WORDS-1:0]         line_i,
    input  logic                             dirty_i
);

    logic [NUM_LINES-1:0]      valid_q;
    logic [NUM_LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]       tag_q  [NUM_LINES];
    logic [32*LINE_WORDS-1:0]  data_q [NUM_LINES];

    // Status bits: the only storage cleared by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= dirty_i;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays: no reset, contents are qualified by valid
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_sel_i*32 +: 32] <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller that sits
// in place of the CPU data memory. Hits complete with zero load latency;
// misses stall the CPU while the line is (optionally) written back and then
// refilled over a req/ack handshake to a line-wide backing memory.
// LINE_WORDS must be at least 2.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   addr_i, data_i               CPU byte address / store data
//   MemRead_i, MemWrite_i        load / store strobes (both = store)
//   data_o                       load data (0 unless a load hit)
//   stall_o                      CPU must hold PC and pipeline
//   mem_req_o, mem_write_o       backing-memory request, 1 = write-back
//   mem_addr_o                   line-aligned transfer address
//   mem_wdata_o / mem_rdata_i    victim line / refill line
//   mem_ack_i                    one-cycle transfer completion
// ---------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DCACHE_LINES,
    parameter int LINE_WORDS = DCACHE_LINE_WORDS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  data_i,
    input  logic                         MemRead_i,
    input  logic                         MemWrite_i,
    output logic [31:0]                  data_o,
    output logic                         stall_o,
    output logic                         mem_req_o,
    output logic                         mem_write_o,
    output logic [31:0]                  mem_addr_o,
    output logic [32*LINE_WORDS-1:0]     mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0]     mem_rdata_i,
    input  logic                         mem_ack_i
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int SEL_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS = SEL_BITS + 2;
    localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    dc_state_e              state_q;
    logic [LINE_BITS-1:0]   line_buf_q;

    logic [TAG_BITS-1:0]    req_tag_s;
    logic [IDX_BITS-1:0]    idx_s;
    logic [SEL_BITS-1:0]    sel_s;
    logic                   request_s;
    logic                   is_load_s;
    logic                   hit_s;
    logic                   valid_s;
    logic                   dirty_s;
    logic [TAG_BITS-1:0]    tag_s;
    logic [LINE_BITS-1:0]   line_s;
    logic                   word_we_s;
    logic                   line_we_s;
    logic [LINE_BITS-1:0]   merged_line_s;
    logic                   unused_addr_s;

    assign req_tag_s     = addr_i[31 -: TAG_BITS];
    assign idx_s         = addr_i[OFF_BITS +: IDX_BITS];
    assign sel_s         = addr_i[2 +: SEL_BITS];
    assign unused_addr_s = ^addr_i[1:0];

    assign request_s = MemRead_i | MemWrite_i;
    // A store wins when both strobes are high
    assign is_load_s = MemRead_i & ~MemWrite_i;
    assign hit_s     = valid_s && (tag_s == req_tag_s);

    // Store hits only commit from IDLE; the UPDATE path handles store misses
    assign word_we_s = (state_q == S_IDLE) && MemWrite_i && hit_s;
    assign line_we_s = (state_q == S_UPDATE);

    dcache_sram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (idx_s),
        .valid_o    (valid_s),
        .dirty_o    (dirty_s),
        .tag_o      (tag_s),
        .line_o     (line_s),
        .word_we_i  (word_we_s),
        .word_sel_i (sel_s),
        .word_i     (data_i),
        .line_we_i  (line_we_s),
        .tag_i      (req_tag_s),
        .line_i     (merged_line_s),
        .dirty_i    (MemWrite_i)
    );

    // Refilled line with the pending store word merged in
    always_comb begin
        merged_line_s = line_buf_q;
        if (MemWrite_i) begin
            merged_line_s[sel_s*32 +: 32] = data_i;
        end else begin
            merged_line_s = line_buf_q;
        end
    end

    // Load data and stall are combinational so hits cost no cycle
    always_comb begin
        data_o  = 32'd0;
        stall_o = (state_q != S_IDLE) || (request_s && !hit_s);
        if (is_load_s && hit_s) begin
            data_o = line_s[sel_s*32 +: 32];
        end else begin
            data_o = 32'd0;
        end
    end

    // Miss FSM; memory-side outputs are registered so they hold for a whole transfer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            mem_req_o   <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= '0;
            line_buf_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (request_s && !hit_s) begin
                        mem_req_o <= 1'b1;
                        if (valid_s && dirty_s) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_s, idx_s, {OFF_BITS{1'b0}}};
                            mem_wdata_o <= line_s;
                        end else begin
                            state_q     <= S_REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {req_tag_s, idx_s, {OFF_BITS{1'b0}}};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= S_REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag_s, idx_s, {OFF_BITS{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        state_q    <= S_UPDATE;
                        mem_req_o  <= 1'b0;
                        line_buf_q <= mem_rdata_i;
                    end
                end
                S_UPDATE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
